// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite-style memory read port between IFU and LSU.
// One transaction in flight; a sticky watchdog flags R phases that never complete.
module mem_rd_arbiter #(
  parameter int AW  = 64,
  parameter int DW  = 64,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_ARVALID,
  output logic          ifu_ARREADY,
  input  logic [AW-1:0] ifu_ARADDR,
  input  logic [2:0]    ifu_ARPORT,
  output logic          ifu_RVALID,
  input  logic          ifu_RREADY,
  output logic [DW-1:0] ifu_RDATA,
  output logic [1:0]    ifu_RRESP,
  input  logic          lsu_ARVALID,
  output logic          lsu_ARREADY,
  input  logic [AW-1:0] lsu_ARADDR,
  input  logic [2:0]    lsu_ARPORT,
  output logic          lsu_RVALID,
  input  logic          lsu_RREADY,
  output logic [DW-1:0] lsu_RDATA,
  output logic [1:0]    lsu_RRESP,
  output logic          mem_ARVALID,
  input  logic          mem_ARREADY,
  output logic [AW-1:0] mem_ARADDR,
  output logic [2:0]    mem_ARPORT,
  input  logic          mem_RVALID,
  output logic          mem_RREADY,
  input  logic [DW-1:0] mem_RDATA,
  input  logic [1:0]    mem_RRESP,
  output logic [1:0]    grant,
  output logic          hang
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR_I = 3'd1,
    AR_L = 3'd2,
    R_I  = 3'd3,
    R_L  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_C    = 8'(TMO);
  localparam logic [7:0] TMO_M1_C = 8'(TMO - 1);

  state_t     state_r;
  logic       last_lsu_r;
  logic [1:0] grant_r;
  logic [7:0] cnt_r;
  logic       hang_r;

  logic       ar_i_s, ar_l_s, r_i_s, r_l_s, r_done_s;
  logic [1:0] pick_s;
  state_t     arb_state_s;

  // On a tie the master that did not own the last grant wins.
  function automatic logic [1:0] arb_pick(input logic ifu_v, input logic lsu_v,
                                          input logic last_lsu);
    logic [1:0] pick;
    if (ifu_v && lsu_v) begin
      pick = last_lsu ? 2'b01 : 2'b10;
    end else if (ifu_v) begin
      pick = 2'b01;
    end else if (lsu_v) begin
      pick = 2'b10;
    end else begin
      pick = 2'b00;
    end
    return pick;
  endfunction

  assign ar_i_s   = (state_r == AR_I);
  assign ar_l_s   = (state_r == AR_L);
  assign r_i_s    = (state_r == R_I);
  assign r_l_s    = (state_r == R_L);
  assign r_done_s = mem_RVALID && ((r_i_s && ifu_RREADY) || (r_l_s && lsu_RREADY));
  assign pick_s   = arb_pick(ifu_ARVALID, lsu_ARVALID, last_lsu_r);

  // Next state chosen by the arbitration function.
  always_comb begin
    arb_state_s = IDLE;
    case (pick_s)
      2'b01:   arb_state_s = AR_I;
      2'b10:   arb_state_s = AR_L;
      default: arb_state_s = IDLE;
    endcase
  end

  // Arbiter FSM, registered grant and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_lsu_r <= 1'b1;
      grant_r    <= 2'b00;
      cnt_r      <= 8'd0;
      hang_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, R_I, R_L: begin
          if ((state_r == IDLE) || r_done_s) begin
            state_r <= arb_state_s;
            grant_r <= pick_s;
            if (pick_s != 2'b00) begin
              last_lsu_r <= pick_s[1];
            end
          end else begin
            // R phase still waiting: count, saturate, and latch hang at the limit.
            if (cnt_r != TMO_C) begin
              cnt_r <= cnt_r + 8'd1;
            end
            if (cnt_r >= TMO_M1_C) begin
              hang_r <= 1'b1;
            end
          end
        end
        AR_I, AR_L: begin
          if (mem_ARREADY) begin
            state_r <= (state_r == AR_I) ? R_I : R_L;
            cnt_r   <= 8'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 2'b00;
        end
      endcase
    end
  end

  assign mem_ARVALID = ar_i_s || ar_l_s;
  assign mem_ARADDR  = ar_i_s ? ifu_ARADDR : (ar_l_s ? lsu_ARADDR : {AW{1'b0}});
  assign mem_ARPORT  = ar_i_s ? ifu_ARPORT : (ar_l_s ? lsu_ARPORT : 3'b000);
  assign mem_RREADY  = (r_i_s && ifu_RREADY) || (r_l_s && lsu_RREADY);

  assign ifu_ARREADY = ar_i_s && mem_ARREADY;
  assign ifu_RVALID  = r_i_s && mem_RVALID;
  assign ifu_RDATA   = r_i_s ? mem_RDATA : {DW{1'b0}};
  assign ifu_RRESP   = r_i_s ? mem_RRESP : 2'b00;

  assign lsu_ARREADY = ar_l_s && mem_ARREADY;
  assign lsu_RVALID  = r_l_s && mem_RVALID;
  assign lsu_RDATA   = r_l_s ? mem_RDATA : {DW{1'b0}};
  assign lsu_RRESP   = r_l_s ? mem_RRESP : 2'b00;

  assign grant = grant_r;
  assign hang  = hang_r;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_rd_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_ARVALID, ifu_ARREADY, ifu_RVALID, ifu_RREADY;
  logic [AW-1:0] ifu_ARADDR;
  logic [2:0]    ifu_ARPORT;
  logic [DW-1:0] ifu_RDATA;
  logic [1:0]    ifu_RRESP;
  logic          lsu_ARVALID, lsu_ARREADY, lsu_RVALID, lsu_RREADY;
  logic [AW-1:0] lsu_ARADDR;
  logic [2:0]    lsu_ARPORT;
  logic [DW-1:0] lsu_RDATA;
  logic [1:0]    lsu_RRESP;
  logic          mem_ARVALID, mem_ARREADY, mem_RVALID, mem_RREADY;
  logic [AW-1:0] mem_ARADDR;
  logic [2:0]    mem_ARPORT;
  logic [DW-1:0] mem_RDATA;
  logic [1:0]    mem_RRESP;
  logic [1:0]    grant;
  logic          hang;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.AW(AW), .DW(DW), .TMO(255)) dut (
    .clk(clk), .rst(rst),
    .ifu_ARVALID(ifu_ARVALID), .ifu_ARREADY(ifu_ARREADY), .ifu_ARADDR(ifu_ARADDR),
    .ifu_ARPORT(ifu_ARPORT), .ifu_RVALID(ifu_RVALID), .ifu_RREADY(ifu_RREADY),
    .ifu_RDATA(ifu_RDATA), .ifu_RRESP(ifu_RRESP),
    .lsu_ARVALID(lsu_ARVALID), .lsu_ARREADY(lsu_ARREADY), .lsu_ARADDR(lsu_ARADDR),
    .lsu_ARPORT(lsu_ARPORT), .lsu_RVALID(lsu_RVALID), .lsu_RREADY(lsu_RREADY),
    .lsu_RDATA(lsu_RDATA), .lsu_RRESP(lsu_RRESP),
    .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY), .mem_ARADDR(mem_ARADDR),
    .mem_ARPORT(mem_ARPORT), .mem_RVALID(mem_RVALID), .mem_RREADY(mem_RREADY),
    .mem_RDATA(mem_RDATA), .mem_RRESP(mem_RRESP),
    .grant(grant), .hang(hang)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (0 none, 1 IFU, 2 LSU), whether its address was accepted,
  // who won last, how long the data phase has waited, and the sticky hang flag.
  int m_owner, m_last, m_wait;
  bit m_data, m_hang, model_ok, ifu_hs, lsu_hs;

  function automatic int winner(input bit iv, input bit lv, input int last);
    if (iv && lv) return (last == 1) ? 2 : 1;
    if (iv) return 1;
    if (lv) return 2;
    return 0;
  endfunction

  initial begin
    model_ok = 1'b0;
    m_owner = 0; m_last = 2; m_wait = 0; m_data = 1'b0; m_hang = 1'b0;
    ifu_hs = 1'b0; lsu_hs = 1'b0;
    forever begin
      @(posedge clk);
      ifu_hs = (m_owner == 1) && !m_data && mem_ARREADY && ifu_ARVALID;
      lsu_hs = (m_owner == 2) && !m_data && mem_ARREADY && lsu_ARVALID;
      if (rst) begin
        m_owner = 0; m_last = 2; m_wait = 0; m_data = 1'b0; m_hang = 1'b0;
        model_ok = 1'b1;
      end else if (m_owner == 0 ||
                   (m_data && mem_RVALID && ((m_owner == 1) ? ifu_RREADY : lsu_RREADY))) begin
        m_owner = winner(ifu_ARVALID, lsu_ARVALID, m_last);
        m_data = 1'b0;
        if (m_owner != 0) m_last = m_owner;
      end else if (!m_data) begin
        if (mem_ARREADY) begin
          m_data = 1'b1;
          m_wait = 0;
        end
      end else begin
        if (m_wait < 255) m_wait++;
        if (m_wait >= 255) m_hang = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        bit ar, rd, oi, ol;
        ar = (m_owner != 0) && !m_data;
        rd = (m_owner != 0) && m_data;
        oi = (m_owner == 1);
        ol = (m_owner == 2);
        chk("grant", 64'(grant), (m_owner == 1) ? 64'd1 : ((m_owner == 2) ? 64'd2 : 64'd0));
        chk("hang", 64'(hang), 64'(m_hang));
        chk("mem_ARVALID", 64'(mem_ARVALID), 64'(ar));
        chk("mem_RREADY", 64'(mem_RREADY),
            64'(rd && (oi ? ifu_RREADY : lsu_RREADY)));
        chk("ifu_ARREADY", 64'(ifu_ARREADY), 64'(ar && oi && mem_ARREADY));
        chk("lsu_ARREADY", 64'(lsu_ARREADY), 64'(ar && ol && mem_ARREADY));
        chk("ifu_RVALID", 64'(ifu_RVALID), 64'(rd && oi && mem_RVALID));
        chk("lsu_RVALID", 64'(lsu_RVALID), 64'(rd && ol && mem_RVALID));
        chk("ifu_RDATA", ifu_RDATA, (rd && oi) ? mem_RDATA : 64'd0);
        chk("lsu_RDATA", lsu_RDATA, (rd && ol) ? mem_RDATA : 64'd0);
        chk("ifu_RRESP", 64'(ifu_RRESP), (rd && oi) ? 64'(mem_RRESP) : 64'd0);
        chk("lsu_RRESP", 64'(lsu_RRESP), (rd && ol) ? 64'(mem_RRESP) : 64'd0);
        if (ar) begin
          chk("mem_ARADDR", mem_ARADDR, oi ? ifu_ARADDR : lsu_ARADDR);
          chk("mem_ARPORT", 64'(mem_ARPORT), oi ? 64'(ifu_ARPORT) : 64'(lsu_ARPORT));
        end else if (m_owner == 0) begin
          chk("idle_ARADDR", mem_ARADDR, 64'd0);
          chk("idle_ARPORT", 64'(mem_ARPORT), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_ar, n_i, n_l;

  initial begin
    rst = 1'b1;
    ifu_ARVALID = 1'b0; ifu_ARADDR = 64'd0; ifu_ARPORT = 3'd0; ifu_RREADY = 1'b0;
    lsu_ARVALID = 1'b0; lsu_ARADDR = 64'd0; lsu_ARPORT = 3'd0; lsu_RREADY = 1'b0;
    mem_ARREADY = 1'b0; mem_RVALID = 1'b0; mem_RDATA = 64'd0; mem_RRESP = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_hang", 64'(hang), 64'd0);
    chk("reset_arvalid", 64'(mem_ARVALID), 64'd0);

    // IFU-only read
    ifu_ARVALID = 1'b1; ifu_ARADDR = 64'h8000_0000; ifu_ARPORT = 3'b010;
    mem_ARREADY = 1'b1; mem_RVALID = 1'b1; mem_RDATA = 64'h0010_0073; mem_RRESP = 2'b00;
    ifu_RREADY = 1'b1; lsu_RREADY = 1'b1;
    #1 chk("t1_idle_latency", 64'(mem_ARVALID), 64'd0);
    tick(); #1;
    chk("t1_arvalid", 64'(mem_ARVALID), 64'd1);
    chk("t1_araddr", mem_ARADDR, 64'h8000_0000);
    chk("t1_grant_ar", 64'(grant), 64'd1);
    tick(); ifu_ARVALID = 1'b0; #1;
    chk("t1_rvalid", 64'(ifu_RVALID), 64'd1);
    chk("t1_rdata", ifu_RDATA, 64'h0010_0073);
    chk("t1_lsu_rvalid", 64'(lsu_RVALID), 64'd0);
    chk("t1_grant_r", 64'(grant), 64'd1);
    tick(); #1;
    chk("t1_idle_grant", 64'(grant), 64'd0);

    // Simultaneous first requests after reset
    rst = 1'b1;
    tick(); rst = 1'b0;
    ifu_ARVALID = 1'b1; ifu_ARADDR = 64'h8000_0004;
    lsu_ARVALID = 1'b1; lsu_ARADDR = 64'h8000_1000; lsu_ARPORT = 3'b001;
    tick(); #1;
    chk("t2_first_grant", 64'(grant), 64'd1);
    chk("t2_first_addr", mem_ARADDR, 64'h8000_0004);
    chk("t2_lsu_arready", 64'(lsu_ARREADY), 64'd0);
    tick(); ifu_ARVALID = 1'b0;
    tick(); #1;
    chk("t2_second_grant", 64'(grant), 64'd2);
    chk("t2_second_addr", mem_ARADDR, 64'h8000_1000);
    chk("t2_no_bubble", 64'(mem_ARVALID), 64'd1);
    tick(); lsu_ARVALID = 1'b0;
    tick(); #1;
    chk("t2_idle", 64'(grant), 64'd0);

    // Continuous contention: 8 transactions alternate
    ifu_ARVALID = 1'b1; lsu_ARVALID = 1'b1;
    n_ar = 0; n_i = 0; n_l = 0;
    for (int k = 0; k < 16; k++) begin
      tick(); #1;
      if (mem_ARVALID) begin
        chk("t3_alternate", 64'(grant), (n_ar % 2 == 0) ? 64'd1 : 64'd2);
        if (grant == 2'b01) n_i++;
        if (grant == 2'b10) n_l++;
        n_ar++;
      end
    end
    chk("t3_ar_count", 64'(n_ar), 64'd8);
    chk("t3_ifu_count", 64'(n_i), 64'd4);
    chk("t3_lsu_count", 64'(n_l), 64'd4);
    ifu_ARVALID = 1'b0; lsu_ARVALID = 1'b0;
    tick();

    // Memory stalls the address phase for 5 cycles
    mem_ARREADY = 1'b0;
    ifu_ARVALID = 1'b1; ifu_ARADDR = 64'h8000_0100;
    lsu_ARVALID = 1'b1; lsu_ARADDR = 64'h8000_2000;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      chk("t4_addr_stable", mem_ARADDR, 64'h8000_0100);
      chk("t4_grant", 64'(grant), 64'd1);
      chk("t4_other_arready", 64'(lsu_ARREADY), 64'd0);
      chk("t4_own_arready", 64'(ifu_ARREADY), 64'd0);
    end
    mem_ARREADY = 1'b1;
    #1 chk("t4_arready_pass", 64'(ifu_ARREADY), 64'd1);
    tick(); ifu_ARVALID = 1'b0;
    tick(); mem_RRESP = 2'b10;

    // LSU error response passes through and completes
    tick(); lsu_ARVALID = 1'b0; ifu_ARVALID = 1'b1; ifu_ARADDR = 64'h8000_0200;
    #1;
    chk("t5_lsu_rresp", 64'(lsu_RRESP), 64'd2);
    chk("t5_lsu_rvalid", 64'(lsu_RVALID), 64'd1);
    chk("t5_ifu_rresp", 64'(ifu_RRESP), 64'd0);
    tick(); #1;
    chk("t5_next_grant", 64'(grant), 64'd1);
    chk("t5_next_addr", mem_ARADDR, 64'h8000_0200);

    // Memory never returns data: watchdog
    mem_RRESP = 2'b00;
    tick(); ifu_ARVALID = 1'b0; mem_RVALID = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      #1 chk("t6_hang_early", 64'(hang), 64'd0);
      tick();
    end
    #1;
    chk("t6_hang_set", 64'(hang), 64'd1);
    chk("t6_grant_kept", 64'(grant), 64'd1);
    repeat (20) tick();
    #1;
    chk("t6_hang_sticky", 64'(hang), 64'd1);
    chk("t6_not_aborted", 64'(grant), 64'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    chk("t6_rst_hang", 64'(hang), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd0);
    chk("t6_rst_arvalid", 64'(mem_ARVALID), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (ifu_hs) ifu_ARVALID = 1'b0;
      if (lsu_hs) lsu_ARVALID = 1'b0;
      if (!ifu_ARVALID && $urandom_range(0, 2) == 0) begin
        ifu_ARVALID = 1'b1;
        ifu_ARADDR = {$urandom, $urandom};
        ifu_ARPORT = 3'($urandom);
      end
      if (!lsu_ARVALID && $urandom_range(0, 2) == 0) begin
        lsu_ARVALID = 1'b1;
        lsu_ARADDR = {$urandom, $urandom};
        lsu_ARPORT = 3'($urandom);
      end
      ifu_RREADY = ($urandom_range(0, 3) != 0);
      lsu_RREADY = ($urandom_range(0, 3) != 0);
      mem_ARREADY = ($urandom_range(0, 2) != 0);
      mem_RVALID = ($urandom_range(0, 2) != 0);
      mem_RDATA = {$urandom, $urandom};
      mem_RRESP = 2'($urandom);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
